// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: key debounce, RUN/SET mode FSM and counter-chain pulses.
// Define WATCH_AUTOREPEAT_EN for held-key auto-repeat in SET_HOUR/SET_MIN.
module watch_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYC   = 16,
    parameter int unsigned TIMEOUT_S      = 10,
    parameter int unsigned REPEAT_DLY_CYC = 512,
    parameter int unsigned REPEAT_PER_CYC = 128
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       tick_1hz,
    input  logic       KEY_MODE,
    input  logic       KEY_INC,
    input  logic       sec_at_max,
    input  logic       min_at_max,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       hour_inc,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blink
);
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int TO_W = $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    state_t state, state_nx;

    // bit 0 = mode key, bit 1 = inc key
    logic [1:0]            raw, sync1, sync2, db, db_q;
    logic [1:0][DB_W-1:0]  db_cnt;
    logic [TO_W-1:0]       to_cnt, to_cnt_d;
    logic mode_press, inc_press, rep, inc_ev, timeout;
    logic sec_inc_d, min_inc_d, hour_inc_d, sec_clr_d, blink_d;

    assign raw = {KEY_INC, KEY_MODE};

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            db     <= 2'b11;
            db_q   <= 2'b11;
            db_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign mode_press = db_q[0] & ~db[0];
    assign inc_press  = db_q[1] & ~db[1];
    // a mode press in the same cycle swallows the inc event
    assign inc_ev     = (inc_press | rep) & ~mode_press;

`ifdef WATCH_AUTOREPEAT_EN
    localparam int RP_W = $clog2(REPEAT_DLY_CYC + 1);

    logic [RP_W-1:0] rp_cnt;
    logic            hold_ok;

    assign hold_ok = ~db[1] && (state == SET_HOUR || state == SET_MIN)
                     && (state_nx == state);
    assign rep     = ~db[1] && (rp_cnt == RP_W'(REPEAT_DLY_CYC));

    // rp_cnt = cycles since the press; 0 means disarmed
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            rp_cnt <= '0;
        end else if (!hold_ok) begin
            rp_cnt <= '0;
        end else if (inc_press) begin
            rp_cnt <= RP_W'(1);
        end else if (rep) begin
            rp_cnt <= RP_W'(REPEAT_DLY_CYC - REPEAT_PER_CYC + 1);
        end else if (rp_cnt != '0) begin
            rp_cnt <= rp_cnt + RP_W'(1);
        end
    end
`else
    logic [31:0] unused_rep;
    assign unused_rep = REPEAT_DLY_CYC ^ REPEAT_PER_CYC;
    assign rep        = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        timeout    = (state != RUN) && tick_1hz
                     && (to_cnt == TO_W'(TIMEOUT_S - 1));
        sec_inc_d  = 1'b0;
        min_inc_d  = 1'b0;
        hour_inc_d = 1'b0;
        sec_clr_d  = 1'b0;
        to_cnt_d   = to_cnt;
        blink_d    = blink;

        if (timeout) begin
            state_nx = RUN;
        end else if (mode_press) begin
            unique case (state)
                RUN:      state_nx = SET_HOUR;
                SET_HOUR: state_nx = SET_MIN;
                SET_MIN:  state_nx = SET_SEC;
                SET_SEC:  state_nx = RUN;
            endcase
        end

        unique case (state)
            RUN: begin
                sec_inc_d  = tick_1hz;
                min_inc_d  = tick_1hz & sec_at_max;
                hour_inc_d = tick_1hz & sec_at_max & min_at_max;
            end
            SET_HOUR: hour_inc_d = inc_ev;
            SET_MIN:  min_inc_d  = inc_ev;
            SET_SEC:  sec_clr_d  = inc_ev;
        endcase

        if (state_nx == RUN || state_nx != state) begin
            to_cnt_d = '0;
            blink_d  = 1'b0;
        end else begin
            if (inc_press | rep) begin
                to_cnt_d = '0;
            end else if (tick_1hz) begin
                to_cnt_d = to_cnt + TO_W'(1);
            end
            if (tick_1hz) begin
                blink_d = ~blink;
            end
        end
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state    <= RUN;
            to_cnt   <= '0;
            blink    <= 1'b0;
            sec_inc  <= 1'b0;
            min_inc  <= 1'b0;
            hour_inc <= 1'b0;
            sec_clr  <= 1'b0;
        end else begin
            state    <= state_nx;
            to_cnt   <= to_cnt_d;
            blink    <= blink_d;
            sec_inc  <= sec_inc_d;
            min_inc  <= min_inc_d;
            hour_inc <= hour_inc_d;
            sec_clr  <= sec_clr_d;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb_watch_set_ctrl: directed and random key/tick stimulus checked every
// cycle against a behavioural model of the watch set controller.
`timescale 1ns/1ps
module tb_watch_set_ctrl;
    localparam int DB = 16;
    localparam int TO = 10;
    localparam int RD = 512;
    localparam int RP = 128;
    localparam int LOGN = 32768;

    logic clk = 1'b0;
    logic RESET = 1'b1;
    logic tick_1hz = 1'b0;
    logic KEY_MODE = 1'b1;
    logic KEY_INC = 1'b1;
    logic sec_at_max = 1'b0;
    logic min_at_max = 1'b0;
    logic sec_inc, min_inc, hour_inc, sec_clr, blink;
    logic [1:0] mode;

    int vectors = 0;
    int errors = 0;
    bit check_en = 1'b0;

    watch_set_ctrl #(
        .DEBOUNCE_CYC(DB),
        .TIMEOUT_S(TO),
        .REPEAT_DLY_CYC(RD),
        .REPEAT_PER_CYC(RP)
    ) dut (
        .clk(clk),
        .RESET(RESET),
        .tick_1hz(tick_1hz),
        .KEY_MODE(KEY_MODE),
        .KEY_INC(KEY_INC),
        .sec_at_max(sec_at_max),
        .min_at_max(min_at_max),
        .sec_inc(sec_inc),
        .min_inc(min_inc),
        .hour_inc(hour_inc),
        .sec_clr(sec_clr),
        .mode(mode),
        .blink(blink)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit [1:0] raw_log [LOGN];
    int  mcyc = 0;
    bit [1:0] db_m = 2'b11;
    bit [1:0] dbp_m = 2'b11;
    int  m_mode = 0;
    int  ticks_since = 0;
    bit  m_blink = 1'b0;
    bit  armed = 1'b0;
    int  press_cyc = 0;
    bit  e_sec = 0, e_min = 0, e_hour = 0, e_clr = 0;
    bit  mp, ip, rep, tmo, all_diff;
    int  nmode;

    // key level seen by the debouncer in cycle c: raw from two cycles earlier
    function automatic bit sync_of(input int k, input int c);
        if (c < 2) return 1'b1;
        return raw_log[c-2][k];
    endfunction

    always @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            mcyc = 0;
            db_m = 2'b11;
            dbp_m = 2'b11;
            m_mode = 0;
            ticks_since = 0;
            m_blink = 1'b0;
            armed = 1'b0;
            press_cyc = 0;
            e_sec = 0; e_min = 0; e_hour = 0; e_clr = 0;
        end else begin
            raw_log[mcyc % LOGN] = {KEY_INC, KEY_MODE};
            mp = dbp_m[0] && !db_m[0];
            ip = dbp_m[1] && !db_m[1];
            rep = 1'b0;
`ifdef WATCH_AUTOREPEAT_EN
            if (armed && !db_m[1] && (mcyc - press_cyc) >= RD
                && ((mcyc - press_cyc - RD) % RP) == 0)
                rep = 1'b1;
`endif
            e_sec = 0; e_min = 0; e_hour = 0; e_clr = 0;
            if (m_mode == 0) begin
                e_sec  = tick_1hz;
                e_min  = tick_1hz && sec_at_max;
                e_hour = tick_1hz && sec_at_max && min_at_max;
            end else if ((ip || rep) && !mp) begin
                if (m_mode == 1) e_hour = 1;
                if (m_mode == 2) e_min = 1;
                if (m_mode == 3) e_clr = 1;
            end
            tmo = (m_mode != 0) && tick_1hz && (ticks_since == TO - 1);
            if (tmo) nmode = 0;
            else if (mp) nmode = (m_mode + 1) % 4;
            else nmode = m_mode;
            if (nmode == 0 || nmode != m_mode || ip || mp || rep)
                ticks_since = 0;
            else if (tick_1hz)
                ticks_since++;
            if (nmode == 0 || nmode != m_mode) m_blink = 1'b0;
            else if (tick_1hz) m_blink = !m_blink;
            if (db_m[1] || nmode != m_mode || !(m_mode == 1 || m_mode == 2))
                armed = 1'b0;
            else if (ip) begin
                armed = 1'b1;
                press_cyc = mcyc;
            end
            dbp_m = db_m;
            for (int k = 0; k < 2; k++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++)
                    if (sync_of(k, mcyc - j) == db_m[k]) all_diff = 1'b0;
                if (all_diff) db_m[k] = sync_of(k, mcyc);
            end
            m_mode = nmode;
            mcyc++;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            vectors++;
            if ({sec_inc, min_inc, hour_inc, sec_clr, mode, blink} !==
                {e_sec, e_min, e_hour, e_clr, 2'(m_mode), m_blink}) begin
                errors++;
                $display("FAIL model_compare @%0t: got sec=%b min=%b hour=%b clr=%b mode=%0d blink=%b, expected sec=%b min=%b hour=%b clr=%b mode=%0d blink=%b",
                         $time, sec_inc, min_inc, hour_inc, sec_clr, mode, blink,
                         e_sec, e_min, e_hour, e_clr, m_mode, m_blink);
            end
        end
    end

    // ---------------- pulse counters for directed checks ----------------
    int cnt_sec = 0, cnt_min = 0, cnt_hour = 0, cnt_clr = 0;

    always @(posedge clk) begin
        #1;
        if (sec_inc) cnt_sec++;
        if (min_inc) cnt_min++;
        if (hour_inc) cnt_hour++;
        if (sec_clr) cnt_clr++;
    end

    task automatic lit(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic press(input bit which);
        if (which) KEY_INC = 1'b0;
        else KEY_MODE = 1'b0;
        repeat (24) @(negedge clk);
        KEY_INC = 1'b1;
        KEY_MODE = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    task automatic tick_gap();
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    function automatic int pick_dur(input bit inc_key, input bit level);
        int r;
        r = $urandom_range(0, 99);
        if (inc_key && level == 1'b0 && r < 8) return $urandom_range(520, 800);
        if (r < 40) return $urandom_range(1, 20);
        return $urandom_range(20, 70);
    endfunction

    int seen, c0, c1, dm, di;

    initial begin
        #1 RESET = 1'b0;
        check_en = 1'b1;
        repeat (3) @(negedge clk);
        lit("reset_mode", int'(mode), 0);
        lit("reset_outputs", int'({sec_inc, min_inc, hour_inc, sec_clr, blink}), 0);
        RESET = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            tick_1hz = 1'b1;
            @(negedge clk);
            tick_1hz = 1'b0;
            lit("run_sec_inc", int'(sec_inc), 1);
            lit("run_no_min_inc", int'(min_inc), 0);
            @(negedge clk);
            lit("run_sec_inc_width", int'(sec_inc), 0);
            @(negedge clk);
        end

        sec_at_max = 1'b1;
        min_at_max = 1'b1;
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        sec_at_max = 1'b0;
        min_at_max = 1'b0;
        lit("run_full_carry", int'({sec_inc, min_inc, hour_inc}), 7);
        @(negedge clk);
        lit("run_carry_width", int'({sec_inc, min_inc, hour_inc}), 0);

        KEY_MODE = 1'b0;
        repeat (10) @(negedge clk);
        KEY_MODE = 1'b1;
        repeat (5) @(negedge clk);
        KEY_MODE = 1'b0;
        seen = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 30) KEY_MODE = 1'b1;
            if (seen == 0 && mode == 2'd1) seen = i;
        end
        lit("mode_press_latency", seen, 19);
        repeat (20) @(negedge clk);
        press(0);
        lit("mode_step2", int'(mode), 2);
        press(0);
        lit("mode_step3", int'(mode), 3);
        press(0);
        lit("mode_wrap", int'(mode), 0);

        press(0);
        press(0);
        lit("enter_set_min", int'(mode), 2);
        sec_at_max = 1'b1;
        min_at_max = 1'b1;
        c0 = cnt_min;
        c1 = cnt_hour;
        press(1);
        lit("set_min_one_inc", cnt_min - c0, 1);
        lit("set_min_no_carry", cnt_hour - c1, 0);
        sec_at_max = 1'b0;
        min_at_max = 1'b0;
        lit("set_blink_entry", int'(blink), 0);
        c0 = cnt_sec;
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        lit("blink_toggle_on", int'(blink), 1);
        @(negedge clk);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        lit("blink_toggle_off", int'(blink), 0);
        lit("set_tick_no_sec_inc", cnt_sec - c0, 0);

        press(0);
        lit("enter_set_sec", int'(mode), 3);
        c0 = cnt_clr;
        c1 = cnt_sec;
        press(1);
        lit("set_sec_clr", cnt_clr - c0, 1);
        lit("set_sec_no_inc", cnt_sec - c1, 0);
        press(0);
        lit("back_to_run", int'(mode), 0);

        press(0);
        lit("enter_set_hour", int'(mode), 1);
        for (int i = 0; i < 9; i++) tick_gap();
        lit("no_timeout_at_9", int'(mode), 1);
        c0 = cnt_hour;
        press(1);
        lit("set_hour_one_inc", cnt_hour - c0, 1);
        for (int i = 0; i < 9; i++) tick_gap();
        lit("timeout_restarted", int'(mode), 1);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        lit("timeout_mode", int'(mode), 0);
        lit("timeout_blink", int'(blink), 0);
        repeat (3) @(negedge clk);

        press(0);
        c0 = cnt_hour;
        KEY_INC = 1'b0;
        repeat (RD + 3 * RP) @(negedge clk);
        KEY_INC = 1'b1;
        repeat (40) @(negedge clk);
`ifdef WATCH_AUTOREPEAT_EN
        lit("repeat_hour_pulses", cnt_hour - c0, 4);
`else
        lit("repeat_hour_pulses", cnt_hour - c0, 1);
`endif
        lit("repeat_still_set_hour", int'(mode), 1);
        press(0);
        press(0);
        press(0);
        lit("directed_end_run", int'(mode), 0);

        dm = pick_dur(1'b0, 1'b1);
        di = pick_dur(1'b1, 1'b1);
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            tick_1hz = tick_1hz ? 1'b0 : ($urandom_range(0, 7) == 0);
            sec_at_max = 1'($urandom_range(0, 1));
            min_at_max = 1'($urandom_range(0, 1));
            dm--;
            if (dm <= 0) begin
                KEY_MODE = ~KEY_MODE;
                dm = pick_dur(1'b0, KEY_MODE);
            end
            di--;
            if (di <= 0) begin
                KEY_INC = ~KEY_INC;
                di = pick_dur(1'b1, KEY_INC);
            end
            if (c == 4000) #2 RESET = 1'b0;
            if (c == 4003) RESET = 1'b1;
        end
        tick_1hz = 1'b0;
        repeat (5) @(negedge clk);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/watch_set_ctrl.md
# watch_set_ctrl

Mode and time-set controller for the watch counter chain (seconds/minutes modulo-60, hours). It owns the two user keys, debounces them, runs a RUN/SET_HOUR/SET_MIN/SET_SEC state machine, and issues single-cycle increment and clear pulses to the counter chain. In RUN it forwards the 1 Hz tick with carry gating; in SET states it halts timekeeping and converts key presses into field increments. It is fully synchronous to `clk`, replacing key-derived clocking of the counters.

## Interface
- `DEBOUNCE_CYC`, 16: consecutive stable `clk` cycles required to accept a key level change.
- `TIMEOUT_S`, 10: ticks without a key event in a SET state before automatic return to RUN.
- `REPEAT_DLY_CYC`, 512: cycles `KEY_INC` is held before auto-repeat starts (only with `WATCH_AUTOREPEAT_EN`).
- `REPEAT_PER_CYC`, 128: cycles between auto-repeat pulses (only with `WATCH_AUTOREPEAT_EN`).

- `clk` input 1: system clock; all state on rising edge.
- `RESET` input 1: reset, asynchronous, active-low.
- `tick_1hz` input 1: one-cycle 1 Hz enable pulse.
- `KEY_MODE` input 1: raw mode key, active-low, asynchronous.
- `KEY_INC` input 1: raw increment key, active-low, asynchronous.
- `sec_at_max` input 1: seconds counter equals 59.
- `min_at_max` input 1: minutes counter equals 59.
- `sec_inc`, `min_inc`, `hour_inc` output 1: one-cycle increment pulses to counters.
- `sec_clr` output 1: one-cycle synchronous clear to seconds counter.
- `mode` output 2: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
- `blink` output 1: display blink phase for the field being set.

## Operation
- Keys: 2-flop synchronizer (reset value 1), then debouncer. Debounced level takes the synchronized value after it differs from the current debounced level for `DEBOUNCE_CYC` consecutive cycles; any mismatch gap restarts the count. Press event = debounced 1→0, one cycle wide. Release creates no event.
- FSM: a mode press advances RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
- RUN: a tick produces `sec_inc`; `min_inc` if `sec_at_max`; `hour_inc` if `sec_at_max` and `min_at_max`. Carry inputs are sampled in the tick cycle. Inc presses are ignored.
- SET states: ticks never produce increments. Inc press produces `hour_inc` in SET_HOUR, `min_inc` alone in SET_MIN (no carry to hours), and `sec_clr` in SET_SEC.
- Timeout counter clears on any press event or repeat pulse and on entering a SET state. It counts ticks in SET states; on reaching `TIMEOUT_S`, it forces RUN.
- `blink`: 0 in RUN; set to 0 on entering any SET state; toggles on each tick while in a SET state.
- Simultaneous mode and inc press: mode wins and inc is dropped. Simultaneous mode press and timeout in the same cycle: result is RUN.
- Reset, async, at any time: `mode`=0, all pulse outputs 0, `blink`=0, debounce/timeout/repeat counters 0, debounced levels 1. A key held through reset release registers as a press after 2+`DEBOUNCE_CYC` cycles.

## Timing
- Event in cycle N, whether tick, press or repeat: the pulse output is registered and high for exactly cycle N+1.
- Mode change is visible on `mode` in cycle N+1 after the press cycle N. A tick in cycle N is processed using the state in cycle N.
- Raw key edge to press event: 2 synchronizer cycles + `DEBOUNCE_CYC`. To output pulse: +1.
- No two increment pulses to the same field in consecutive cycles.

## Configuration
- `WATCH_AUTOREPEAT_EN` defined: in SET_HOUR/SET_MIN, if `KEY_INC` stays debounced-low for `REPEAT_DLY_CYC` cycles after the press, one extra pulse is issued, then one every `REPEAT_PER_CYC` cycles until release or a mode change. There is no repeat in SET_SEC or RUN.
- Undefined: exactly one pulse per press. `REPEAT_*` parameters are unused, and the repeat logic is absent.

## Test plan
- Reset with keys released: all outputs 0. Deassert, then 3 ticks in RUN with `sec_at_max`=0 → 3 `sec_inc` pulses, each one cycle after its tick, and no `min_inc`.
- RUN tick with `sec_at_max`=1 and `min_at_max`=1 → `sec_inc`, `min_inc` and `hour_inc` all high in the same single cycle.
- `KEY_MODE` low with a 10-cycle glitch, then held low 30 cycles (`DEBOUNCE_CYC`=16) → one mode step to 1, at cycle 2+16+1 after the stable low begins. Then 3 more presses → `mode` 2, 3, 0.
- In SET_MIN: one inc press → exactly one `min_inc`, no `hour_inc`, even with `min_at_max`=1. In SET_SEC: inc press → one `sec_clr`. Ticks in SET states → no increments, and `blink` toggles.
- In SET_HOUR with no keys: 10 ticks → `mode` returns to 0 after the 10th tick, with `blink`=0. A press at tick 9 restarts the count.
- With `WATCH_AUTOREPEAT_EN`, holding inc in SET_HOUR for 512+3×128 cycles after the press → 4 `hour_inc` pulses. Without the macro → 1.
